apb_master_bridge: RTL and testbench

- Converts the single-beat request/accept/ack interface used by the SDRAM core port into APB3/APB4 master transactions.
- Lets core-side initiators reach APB peripherals (UART, GPIO, SPI, the SDRAM APB slave) through one APB master port.
- Handles exactly one outstanding transfer.
- A watchdog bounds the ACCESS phase so a dead slave cannot hang the requester.

---
 rtl/apb_bridge_pkg.sv | 14 +
 rtl/apb_master_bridge_if.sv | 42 ++++
 rtl/apb_master_bridge_wdog.sv | 40 ++++
 rtl/apb_master_bridge.sv | 131 +++++++++++++
 tb/tb_apb_master_bridge.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared types and constants for the APB master bridge
package apb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam int DATA_W_DEF = 32;
   localparam int STRB_W     = DATA_W_DEF / 8;

endpackage

// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - core request port plus APB master port bundle
// master: the bridge view (drives accept/ack/read data and the APB request side)
// slave : the environment view (core requester and APB slave)
interface apb_master_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [DATA_W/8-1:0] inport_wr_i;
   logic                inport_rd_i;
   logic [7:0]          inport_len_i;
   logic [ADDR_W-1:0]   inport_addr_i;
   logic [DATA_W-1:0]   inport_write_data_i;
   logic                inport_accept_o;
   logic                inport_ack_o;
   logic                inport_error_o;
   logic [DATA_W-1:0]   inport_read_data_o;

   logic [ADDR_W-1:0]   out_paddr;
   logic                out_psel;
   logic                out_penable;
   logic [2:0]          out_pprot;
   logic                out_pwrite;
   logic [DATA_W-1:0]   out_pwdata;
   logic [DATA_W/8-1:0] out_pstrb;
   logic                out_pready;
   logic [DATA_W-1:0]   out_prdata;
   logic                out_pslverr;

   modport master (
      input  inport_wr_i, inport_rd_i, inport_len_i, inport_addr_i, inport_write_data_i,
      output inport_accept_o, inport_ack_o, inport_error_o, inport_read_data_o,
      output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
      input  out_pready, out_prdata, out_pslverr
   );

   modport slave (
      output inport_wr_i, inport_rd_i, inport_len_i, inport_addr_i, inport_write_data_i,
      input  inport_accept_o, inport_ack_o, inport_error_o, inport_read_data_o,
      input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
      output out_pready, out_prdata, out_pslverr
   );
endinterface

// File: rtl/apb_master_bridge_wdog.sv
// rtl/apb_master_bridge_wdog.sv - ACCESS-phase watchdog counter
// clock/reset : system clock, synchronous active-high reset
// clear       : zero the counter (bridge not in ACCESS)
// enable      : count one stalled ACCESS cycle
// expire      : stalled cycle that completes the budget; counter self-clears
module apb_wdog #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = &{1'b0, clock, reset, clear, enable};
         assign expire = 1'b0;
      end else begin : g_on
         localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
         logic [CW-1:0] count;

         // Expire on the stalled cycle whose index is TIMEOUT_CYCLES-1, so the
         // ACCESS phase lasts exactly TIMEOUT_CYCLES cycles before abort.
         assign expire = enable && (count == LAST);

         always_ff @(posedge clock) begin
            if (reset || clear || expire) begin
               count <= '0;
            end else if (enable) begin
               count <= count + 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-beat core request port to APB3/APB4 master
// clock/reset : system clock, synchronous active-high reset
// bus.inport_*: core request (wr strobes / rd / len / addr / wdata) with
//               combinational accept and one-cycle ack/error/read_data
// bus.out_*   : APB master port (paddr, psel, penable, pprot, pwrite, pwdata,
//               pstrb out; pready, prdata, pslverr in)
module apb_master_bridge
   import apb_bridge_pkg::*;
#(
   parameter int         ADDR_W         = 32,
   parameter int         DATA_W         = 32,
   parameter logic [2:0] PPROT          = 3'b000,
   parameter int         TIMEOUT_CYCLES = 256
) (
   input logic                 clock,
   input logic                 reset,
   apb_master_bridge_if.master bus
);

   localparam int SW = DATA_W / 8;

   state_t            state;
   logic [ADDR_W-1:0] paddr_q;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [DATA_W-1:0] pwdata_q;
   logic [SW-1:0]     pstrb_q;
   logic              ack_q;
   logic              error_q;
   logic [DATA_W-1:0] rdata_q;

   logic wr_req;
   logic req;
   logic wd_clear;
   logic wd_enable;
   logic wd_expire;

   // A nonzero strobe marks a write; it wins when rd is also asserted.
   assign wr_req = |bus.inport_wr_i;
   assign req    = wr_req | bus.inport_rd_i;

   assign wd_clear  = (state != ST_ACCESS);
   assign wd_enable = (state == ST_ACCESS) && !bus.out_pready;

   apb_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clock (clock),
      .reset (reset),
      .clear (wd_clear),
      .enable(wd_enable),
      .expire(wd_expire)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         paddr_q   <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         ack_q     <= 1'b0;
         error_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  if (bus.inport_len_i == 8'd0) begin
                     paddr_q  <= bus.inport_addr_i;
                     pwdata_q <= bus.inport_write_data_i;
                     pwrite_q <= wr_req;
                     pstrb_q  <= wr_req ? bus.inport_wr_i : '0;
                     psel_q   <= 1'b1;
                     state    <= ST_SETUP;
                  end else begin
                     // Bursts are unsupported: complete with error, no APB cycle.
                     error_q <= 1'b1;
                     rdata_q <= '0;
                     ack_q   <= 1'b1;
                     state   <= ST_RESP;
                  end
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state     <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (bus.out_pready) begin
                  error_q   <= bus.out_pslverr;
                  rdata_q   <= pwrite_q ? '0 : bus.out_prdata;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  ack_q     <= 1'b1;
                  state     <= ST_RESP;
               end else if (wd_expire) begin
                  error_q   <= 1'b1;
                  rdata_q   <= '0;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  ack_q     <= 1'b1;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               ack_q <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.inport_accept_o    = (state == ST_IDLE) && !reset;
   assign bus.inport_ack_o       = ack_q;
   assign bus.inport_error_o     = error_q;
   assign bus.inport_read_data_o = rdata_q;

   assign bus.out_paddr   = paddr_q;
   assign bus.out_psel    = psel_q;
   assign bus.out_penable = penable_q;
   assign bus.out_pprot   = PPROT;
   assign bus.out_pwrite  = pwrite_q;
   assign bus.out_pwdata  = pwdata_q;
   assign bus.out_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized self-checking bench for apb_master_bridge
module tb_apb_master_bridge;
   import apb_bridge_pkg::*;

   localparam int TO = 8;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_master_bridge #(
      .ADDR_W        (32),
      .DATA_W        (32),
      .PPROT         (3'b000),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_req();
      bus.inport_rd_i         = 1'b0;
      bus.inport_wr_i         = '0;
      bus.inport_len_i        = 8'd0;
      bus.inport_addr_i       = $urandom;
      bus.inport_write_data_i = $urandom;
   endtask

   // One transfer: reference model gives latency / error / data from the rules,
   // and the bench plays the APB slave with 'waits' wait states.
   task automatic run_xfer(input logic is_rd, input logic [STRB_W-1:0] wr, input logic [7:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                           input logic err, input logic [31:0] rdata);
      logic       is_wr;
      logic       legal;
      logic       tmo;
      int         exp_lat;
      logic       exp_err;
      logic [31:0] exp_rdata;
      int         cyc;
      int         acc;
      int         setup_cnt;
      logic       got_ack;
      logic       saw_psel;

      is_wr     = (wr != '0);
      legal     = (len == 8'd0);
      tmo       = legal && (waits >= TO);
      exp_lat   = !legal ? 1 : (tmo ? 2 + TO : 3 + waits);
      exp_err   = !legal ? 1'b1 : (tmo ? 1'b1 : err);
      exp_rdata = (!legal || tmo || is_wr) ? 32'h0 : rdata;

      @(negedge clock);
      bus.inport_rd_i         = is_rd;
      bus.inport_wr_i         = wr;
      bus.inport_len_i        = len;
      bus.inport_addr_i       = addr;
      bus.inport_write_data_i = wdata;
      check_eq("accept_idle", bus.inport_accept_o, 1'b1);
      @(posedge clock);
      #1;
      clear_req();
      cyc = 1; acc = 0; setup_cnt = 0; got_ack = 1'b0; saw_psel = 1'b0;

      for (int k = 0; k < 60 && !got_ack; k++) begin
         check_eq("accept_busy", bus.inport_accept_o, 1'b0);
         if (bus.inport_ack_o) begin
            got_ack = 1'b1;
            bus.out_pready  = 1'b0;
            bus.out_pslverr = 1'b0;
            check_eq("ack_latency", cyc, exp_lat);
            check_eq("ack_error", bus.inport_error_o, exp_err);
            check_eq("ack_rdata", bus.inport_read_data_o, exp_rdata);
            check_eq("psel_dropped", bus.out_psel, 1'b0);
         end else begin
            if (bus.out_psel) begin
               saw_psel = 1'b1;
               check_eq("paddr", bus.out_paddr, addr);
               check_eq("pwrite", bus.out_pwrite, is_wr);
               check_eq("pstrb", bus.out_pstrb, is_wr ? wr : '0);
               check_eq("pwdata", bus.out_pwdata, wdata);
               if (!bus.out_penable) begin
                  setup_cnt++;
                  bus.out_pready  = 1'($urandom_range(0, 1));
                  bus.out_pslverr = 1'($urandom_range(0, 1));
                  bus.out_prdata  = $urandom;
               end else begin
                  acc++;
                  bus.out_pready  = (acc - 1 == waits);
                  bus.out_pslverr = (acc - 1 == waits) ? err : 1'($urandom_range(0, 1));
                  bus.out_prdata  = (acc - 1 == waits) ? rdata : $urandom;
               end
            end else begin
               bus.out_pready = 1'b0;
            end
            @(posedge clock);
            #1;
            cyc++;
         end
      end
      if (!got_ack) check_eq("ack_timeout", 1'b0, 1'b1);
      check_eq("psel_issued", saw_psel, legal);
      check_eq("setup_cycles", setup_cnt, legal ? 1 : 0);

      @(posedge clock);
      #1;
      check_eq("ack_one_cycle", bus.inport_ack_o, 1'b0);
      check_eq("accept_after", bus.inport_accept_o, 1'b1);
   endtask

   task automatic reset_in_access();
      @(negedge clock);
      bus.inport_wr_i         = 4'hF;
      bus.inport_addr_i       = 32'h2000_0010;
      bus.inport_write_data_i = 32'h1234_5678;
      @(posedge clock);
      #1;
      clear_req();
      bus.out_pready = 1'b0;
      @(posedge clock);
      #1;
      check_eq("rst_in_access", {bus.out_psel, bus.out_penable}, 2'b11);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_eq("rst_psel", bus.out_psel, 1'b0);
      check_eq("rst_penable", bus.out_penable, 1'b0);
      check_eq("rst_ack", bus.inport_ack_o, 1'b0);
      check_eq("rst_accept", bus.inport_accept_o, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_eq("accept_post_rst", bus.inport_accept_o, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         check_eq("no_ack_aborted", bus.inport_ack_o, 1'b0);
      end
   endtask

   initial begin
      logic       r_rd;
      logic [3:0] r_wr;
      logic [7:0] r_len;

      reset = 1'b1;
      clear_req();
      bus.out_pready  = 1'b0;
      bus.out_prdata  = '0;
      bus.out_pslverr = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_accept0", bus.inport_accept_o, 1'b0);
      check_eq("rst_psel0", bus.out_psel, 1'b0);
      check_eq("rst_penable0", bus.out_penable, 1'b0);
      check_eq("rst_paddr0", bus.out_paddr, 32'h0);
      check_eq("rst_pwrite0", bus.out_pwrite, 1'b0);
      check_eq("rst_pwdata0", bus.out_pwdata, 32'h0);
      check_eq("rst_pstrb0", bus.out_pstrb, 4'h0);
      check_eq("rst_ack0", bus.inport_ack_o, 1'b0);
      check_eq("rst_error0", bus.inport_error_o, 1'b0);
      check_eq("rst_rdata0", bus.inport_read_data_o, 32'h0);
      check_eq("pprot", bus.out_pprot, 3'b000);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_eq("accept_first", bus.inport_accept_o, 1'b1);

      run_xfer(1'b0, 4'b0011, 8'd0, 32'h1000_0004, 32'hA5A5_1234, 0, 1'b0, 32'h0);
      run_xfer(1'b1, 4'b0000, 8'd0, 32'h1000_0008, 32'h0, 3, 1'b0, 32'hCAFE_F00D);
      run_xfer(1'b1, 4'b0000, 8'd0, 32'h1000_000C, 32'h0, 0, 1'b1, 32'h5555_AAAA);
      run_xfer(1'b0, 4'b1111, 8'd0, 32'h1000_0010, 32'h0BAD_BEEF, 1, 1'b0, 32'h0);
      run_xfer(1'b1, 4'b0000, 8'd0, 32'h1000_0014, 32'h0, 1000, 1'b0, 32'hDEAD_0001);
      run_xfer(1'b1, 4'b0000, 8'd0, 32'h1000_0018, 32'h0, TO - 1, 1'b0, 32'h7777_1111);
      run_xfer(1'b1, 4'b1111, 8'd0, 32'h1000_001C, 32'h4444_3333, 0, 1'b0, 32'h0);
      run_xfer(1'b1, 4'b0000, 8'd3, 32'h1000_0020, 32'h0, 0, 1'b0, 32'h9999_9999);
      reset_in_access();

      for (int n = 0; n < 40; n++) begin
         r_rd  = 1'($urandom_range(0, 1));
         r_wr  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         if (!r_rd && r_wr == 4'h0) r_rd = 1'b1;
         r_len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
         run_xfer(r_rd, r_wr, r_len, $urandom, $urandom, int'($urandom_range(0, TO + 2)),
                  ($urandom_range(0, 3) == 0), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
